mem_unit: RTL and testbench

Data-memory responder at the far end of the memory-stage request path. It accepts one request per handshake: a read/write flag, store width select, load funct3, byte address, store data and destination register. Stores are applied with byte-lane enables. Loads return a sign- or zero-extended value after a registered array read. It sits after `mem_decoder` and feeds the writeback stage.

---
 rtl/mem_unit_if.sv | 31 +++
 rtl/mem_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// mem_unit_if: request/response bundle between the memory-stage requester and
// the mem_unit data-memory responder.
//   master : drives req_valid, rw, store_sel, load_funct3, addr, wdata, rd_in;
//            observes req_ready, resp_valid, rdata, rd_out, misaligned.
//   slave  : the mirror image (used by mem_unit).
interface mem_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              rw;           // 1 = write, 0 = read
    logic [1:0]        store_sel;
    logic [2:0]        load_funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [4:0]        rd_in;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic [4:0]        rd_out;
    logic              misaligned;

    modport master (
        output req_valid, rw, store_sel, load_funct3, addr, wdata, rd_in,
        input  req_ready, resp_valid, rdata, rd_out, misaligned
    );

    modport slave (
        input  req_valid, rw, store_sel, load_funct3, addr, wdata, rd_in,
        output req_ready, resp_valid, rdata, rd_out, misaligned
    );
endinterface

// File: rtl/mem_unit.sv
// mem_unit: single-ported data memory responder for the memory stage.
// Accepts one request per IDLE visit, commits aligned stores with byte-lane
// enables at the accept edge, and answers loads after one registered array
// read cycle with sign/zero-extended data. One-cycle response strobe, no
// response backpressure.
// Ports:
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low reset (array contents are not reset)
//   bus     : mem_unit_if.slave request/response bundle
module mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic       clock,
    input  logic       resetn,
    mem_unit_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    localparam logic       MEM_WRITE = 1'b1;
    localparam logic [1:0] STORE_B   = 2'b00;
    localparam logic [1:0] STORE_H   = 2'b01;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

    state_e        state_q, state_d;

    // Request fields latched at accept, consumed in READ.
    logic [IW-1:0] idx_q;
    logic [1:0]    lo_q;
    logic [2:0]    f3_q;
    logic          mis_q;
    logic [4:0]    rd_q;

    // Response registers, held outside RESP.
    logic [31:0]   rdata_q, rdata_d;
    logic [4:0]    rd_out_q, rd_out_d;
    logic          mis_out_q, mis_out_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          is_wr;
    logic [IW-1:0] idx;
    logic [1:0]    lo;
    logic          mis_now;
    logic [3:0]    be;
    logic [31:0]   lane_data;

    // Upper address bits are deliberately ignored: addresses alias mod depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:IW+2];

    assign idx    = bus.addr[IW+1:2];
    assign lo     = bus.addr[1:0];
    assign is_wr  = (bus.rw == MEM_WRITE);
    assign accept = bus.req_valid && bus.req_ready;

    // Access width decides alignment; writes use store_sel, reads load_funct3.
    always_comb begin
        mis_now   = 1'b0;
        be        = 4'b1111;
        lane_data = bus.wdata;
        if (is_wr) begin
            case (bus.store_sel)
                STORE_B: begin
                    be        = 4'b0001 << lo;
                    lane_data = {4{bus.wdata[7:0]}};
                end
                STORE_H: begin
                    mis_now   = lo[0];
                    be        = lo[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{bus.wdata[15:0]}};
                end
                default: mis_now = |lo;
            endcase
        end else begin
            case (bus.load_funct3)
                3'b000, 3'b100: mis_now = 1'b0;
                3'b001, 3'b101: mis_now = lo[0];
                default:        mis_now = |lo;
            endcase
        end
    end

    function automatic logic [31:0] load_fmt(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b100:  load_fmt = {24'b0, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b101:  load_fmt = {16'b0, h};
            default: load_fmt = w;
        endcase
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_wr ? RESP : READ;
            READ:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by resetn so nothing is accepted while reset is held.
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && resetn;
        bus.resp_valid = (state_q == RESP);
        bus.rdata      = rdata_q;
        bus.rd_out     = rd_out_q;
        bus.misaligned = mis_out_q;
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
            lo_q  <= '0;
            f3_q  <= '0;
            mis_q <= 1'b0;
            rd_q  <= '0;
        end else if (accept) begin
            idx_q <= idx;
            lo_q  <= lo;
            f3_q  <= bus.load_funct3;
            mis_q <= mis_now;
            rd_q  <= bus.rd_in;
        end
    end

    // ---------------- response next-state ----------------
    // Writes load the response at accept; reads load it at the end of READ
    // from the registered array word.
    always_comb begin
        rdata_d   = rdata_q;
        rd_out_d  = rd_out_q;
        mis_out_d = mis_out_q;
        if (accept && is_wr) begin
            rdata_d   = '0;
            rd_out_d  = bus.rd_in;
            mis_out_d = mis_now;
        end else if (state_q == READ) begin
            rdata_d   = mis_q ? 32'b0 : load_fmt(mem_q[idx_q], lo_q, f3_q);
            rd_out_d  = rd_q;
            mis_out_d = mis_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            rd_out_q  <= '0;
            mis_out_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            rd_out_q  <= rd_out_d;
            mis_out_q <= mis_out_d;
        end
    end

    // ---------------- array (no reset) ----------------
    always_ff @(posedge clock) begin
        if (accept && is_wr && !mis_now) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
module tb_mem_unit;
    localparam logic       WR = 1'b1;
    localparam logic       RD = 1'b0;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                           LBU = 3'b100, LHU = 3'b101;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    mem_unit_if #(.ADDR_W(32)) bus ();

    mem_unit #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int cyc = 0;
    int checks = 0, failures = 0;
    int tmo_n = 0, tmo_seen = 0;
    int nexp = 0, nresp = 0;
    bit rst_chk = 0, rdy_chk = 0, end_chk = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: the only process that counts comparisons.
    initial forever begin
        @(negedge clock);
        if (bus.resp_valid === 1'b1) begin
            checks++;
            nresp++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp cyc=%0d rdata=%h rd=%0d mis=%0b",
                         cyc, bus.rdata, bus.rd_out, bus.misaligned);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rdata !== mon_e.rdata || bus.rd_out !== mon_e.rd ||
                    bus.misaligned !== mon_e.mis || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL resp%0d got rdata=%h rd=%0d mis=%0b cyc=%0d want rdata=%h rd=%0d mis=%0b cyc=%0d",
                             mon_e.id, bus.rdata, bus.rd_out, bus.misaligned, cyc,
                             mon_e.rdata, mon_e.rd, mon_e.mis, mon_e.cyc);
                end
            end
        end
        if (rst_chk) begin
            checks++;
            if ({bus.resp_valid, bus.rdata, bus.rd_out, bus.misaligned} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got vld=%b rdata=%h rd=%0d mis=%b want all zero",
                         bus.resp_valid, bus.rdata, bus.rd_out, bus.misaligned);
            end
        end
        if (rdy_chk) begin
            checks++;
            if (bus.req_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_reset got %b want 1", bus.req_ready);
            end
        end
        if (tmo_n != tmo_seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got no req_ready within bound (count %0d)", tmo_n);
            tmo_seen = tmo_n;
        end
        if (end_chk) begin
            checks++;
            if (sb.size() != 0 || nresp != nexp) begin
                failures++;
                $display("FAIL drain got pending=%0d responses=%0d want pending=0 responses=%0d",
                         sb.size(), nresp, nexp);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] er, input logic em, input bit hold, input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            tmo_n++;
            return;
        end
        bus.rw          = wr;
        bus.store_sel   = sel;
        bus.load_funct3 = f3;
        bus.addr        = a;
        bus.wdata       = wd;
        bus.rd_in       = rd;
        bus.req_valid   = 1'b1;
        if (track) begin
            e.id    = nexp;
            e.rdata = er;
            e.rd    = rd;
            e.mis   = em;
            // Accept edge makes cyc+1; writes answer right after, reads one later.
            e.cyc   = cyc + 1 + (wr ? 0 : 1);
            sb.push_back(e);
            nexp++;
        end
        @(posedge clock);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic st(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic em);
        issue(WR, sel, 3'b111, a, wd, rd, 32'h0, em, 1'b0, 1'b1);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] er, input logic em);
        issue(RD, 2'b11, f3, a, 32'hFFFF_FFFF, rd, er, em, 1'b0, 1'b1);
    endtask

    initial begin
        resetn          = 1'b1;
        bus.req_valid   = 1'b0;
        bus.rw          = RD;
        bus.store_sel   = SW;
        bus.load_funct3 = LW;
        bus.addr        = '0;
        bus.wdata       = '0;
        bus.rd_in       = '0;
        #1;
        // Reset held with a live write request that must not be accepted.
        resetn          = 1'b0;
        bus.req_valid   = 1'b1;
        bus.rw          = WR;
        bus.addr        = 32'h50;
        bus.wdata       = 32'hFFFF_FFFF;
        bus.rd_in       = 5'd7;
        rst_chk         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        resetn        = 1'b1;
        bus.req_valid = 1'b0;
        rst_chk       = 1'b0;
        rdy_chk       = 1'b1;
        @(posedge clock);
        #1;
        rdy_chk = 1'b0;

        // Word round trip
        st(SW, 32'h10, 32'hDEAD_BEEF, 5'd1, 1'b0);
        ld(LW, 32'h10, 5'd2, 32'hDEAD_BEEF, 1'b0);

        // Byte/half stores and extension
        st(SW, 32'h20, 32'h0000_0000, 5'd3, 1'b0);
        st(SB, 32'h23, 32'h0000_0080, 5'd4, 1'b0);
        st(SH, 32'h20, 32'h0000_8001, 5'd5, 1'b0);
        ld(LW,  32'h20, 5'd6,  32'h8000_8001, 1'b0);
        ld(LB,  32'h23, 5'd7,  32'hFFFF_FF80, 1'b0);
        ld(LBU, 32'h23, 5'd8,  32'h0000_0080, 1'b0);
        ld(LH,  32'h20, 5'd9,  32'hFFFF_8001, 1'b0);
        ld(LHU, 32'h20, 5'd10, 32'h0000_8001, 1'b0);

        // Misalignment
        st(SW, 32'h30, 32'h1122_3344, 5'd11, 1'b0);
        st(SW, 32'h31, 32'hFFFF_FFFF, 5'd12, 1'b1);
        st(SH, 32'h33, 32'hFFFF_FFFF, 5'd13, 1'b1);
        ld(LW,  32'h30, 5'd14, 32'h1122_3344, 1'b0);
        ld(LH,  32'h33, 5'd15, 32'h0, 1'b1);
        ld(LB,  32'h31, 5'd16, 32'h0000_0033, 1'b0);
        ld(LHU, 32'h32, 5'd17, 32'h0000_1122, 1'b0);
        ld(LW,  32'h32, 5'd18, 32'h0, 1'b1);

        // Aliasing with req_valid held across both requests
        issue(WR, SW, LW, 32'h1000, 32'hA5A5_A5A5, 5'd19, 32'h0, 1'b0, 1'b1, 1'b1);
        issue(RD, SW, LW, 32'h0, 32'h0, 5'd20, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;

        // Reset during READ drops the response, keeps committed data
        st(SW, 32'h40, 32'h1234_5678, 5'd21, 1'b0);
        issue(RD, SW, LW, 32'h40, 32'h0, 5'd22, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn  = 1'b1;
        rdy_chk = 1'b1;
        @(posedge clock);
        #1;
        rdy_chk = 1'b0;
        ld(LW, 32'h40, 5'd23, 32'h1234_5678, 1'b0);

        // Out-of-table selectors fall back to word width
        ld(3'b111, 32'h40, 5'd24, 32'h1234_5678, 1'b0);
        st(2'b11, 32'h44, 32'hCAFE_F00D, 5'd25, 1'b0);
        ld(LW, 32'h44, 5'd26, 32'hCAFE_F00D, 1'b0);
        st(SB, 32'h41, 32'h0000_007F, 5'd27, 1'b0);
        ld(LB, 32'h41, 5'd28, 32'h0000_007F, 1'b0);
        ld(LW, 32'h40, 5'd29, 32'h1234_7F78, 1'b0);

        repeat (4) @(posedge clock);
        #1;
        end_chk = 1'b1;
        @(posedge clock);
        #1;
        end_chk = 1'b0;
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
